// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - two-master round-robin data bus arbiter with DMEM/TBMAN decode
module dbus_arbiter #(
    parameter logic [31:0] TBMAN_BASE = 32'h8000_0000,
    parameter logic [31:0] TBMAN_MASK = 32'hFFFF_0000,
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
    parameter logic [31:0] DMEM_MASK  = 32'hFFFF_C000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        cs_dmem_n,
    output logic        cs_tbman_n,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] read_data_dmem,
    input  logic [31:0] read_data_tbman
);

    localparam logic [1:0] SL_NONE  = 2'd0;
    localparam logic [1:0] SL_DMEM  = 2'd1;
    localparam logic [1:0] SL_TBMAN = 2'd2;

    logic        last_gnt;
    logic        rd_pend;
    logic        rd_master;
    logic [1:0]  rd_slave;

    logic        gnt0, gnt1, any_gnt, active;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_be;
    logic        hit_dmem, hit_tbman;
    logic [1:0]  slave_sel;
    logic [31:0] ret_data;
    logic        ret_valid, ret_err;

    always_comb begin
        // Round-robin: on a tie the master that did not win last time is granted.
        gnt0    = m0_req && (!m1_req || last_gnt);
        gnt1    = m1_req && (!m0_req || !last_gnt);
        any_gnt = gnt0 || gnt1;
        active  = n_rst && any_gnt;

        sel_we    = gnt1 ? m1_we    : m0_we;
        sel_addr  = gnt1 ? m1_addr  : m0_addr;
        sel_wdata = gnt1 ? m1_wdata : m0_wdata;
        sel_be    = gnt1 ? m1_be    : m0_be;

        hit_dmem  = (sel_addr & DMEM_MASK) == DMEM_BASE;
        hit_tbman = !hit_dmem && ((sel_addr & TBMAN_MASK) == TBMAN_BASE);
        slave_sel = hit_dmem ? SL_DMEM : (hit_tbman ? SL_TBMAN : SL_NONE);

        m0_gnt     = n_rst && gnt0;
        m1_gnt     = n_rst && gnt1;
        cs_dmem_n  = !(active && hit_dmem);
        cs_tbman_n = !(active && hit_tbman);
        bus_we     = active && sel_we;
        bus_addr   = active ? sel_addr  : 32'h0;
        bus_wdata  = active ? sel_wdata : 32'h0;
        bus_be     = active ? sel_be    : 4'h0;

        // Return path follows the captured slave, not the current chip selects.
        ret_valid = n_rst && rd_pend;
        ret_err   = ret_valid && (rd_slave == SL_NONE);
        case (rd_slave)
            SL_DMEM:  ret_data = read_data_dmem;
            SL_TBMAN: ret_data = read_data_tbman;
            default:  ret_data = 32'h0;
        endcase

        m0_rvalid = ret_valid && !rd_master;
        m1_rvalid = ret_valid && rd_master;
        m0_err    = ret_err && !rd_master;
        m1_err    = ret_err && rd_master;
        m0_rdata  = m0_rvalid ? ret_data : 32'h0;
        m1_rdata  = m1_rvalid ? ret_data : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            last_gnt  <= 1'b1;
            rd_pend   <= 1'b0;
            rd_master <= 1'b0;
            rd_slave  <= SL_NONE;
        end else begin
            // Reads and unmapped writes both produce a response next cycle.
            rd_pend <= any_gnt && (!sel_we || slave_sel == SL_NONE);
            if (any_gnt) begin
                last_gnt  <= gnt1;
                rd_master <= gnt1;
                rd_slave  <= slave_sel;
            end
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - directed self-checking bench for dbus_arbiter
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        cs_dmem_n, cs_tbman_n, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] read_data_dmem, read_data_tbman;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dbus_arbiter dut (
        .clk(clk), .n_rst(n_rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .cs_dmem_n(cs_dmem_n), .cs_tbman_n(cs_tbman_n), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .read_data_dmem(read_data_dmem), .read_data_tbman(read_data_tbman)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; new inputs are then applied.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        next_cycle();
        next_cycle();
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        drive_m0(1'b1, 1'b1, 32'h0000_0040, 32'hAAAA_AAAA, 4'hF);
        drive_m1(1'b1, 1'b1, 32'h8000_0000, 32'hBBBB_BBBB, 4'hF);
        read_data_dmem  = 32'h1111_1111;
        read_data_tbman = 32'h2222_2222;
        next_cycle();
        #1;
        // Outputs forced idle while reset is held, even with requests present.
        check("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        check("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        check("rst_cs", {30'b0, cs_dmem_n, cs_tbman_n}, 32'd3);
        check("rst_bus_we", {31'b0, bus_we}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
        next_cycle();

        // m0 read from DMEM
        n_rst = 1'b1;
        drive_m0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("rd_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("rd_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        check("rd_cs", {30'b0, cs_dmem_n, cs_tbman_n}, 32'd1);
        check("rd_bus_addr", bus_addr, 32'h0000_0010);
        check("rd_bus_we", {31'b0, bus_we}, 32'd0);
        next_cycle();
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        read_data_dmem  = 32'h1234_5678;
        read_data_tbman = 32'hDEAD_BEEF;
        #1;
        check("rd_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
        check("rd_m0_rdata", m0_rdata, 32'h1234_5678);
        check("rd_m0_err", {31'b0, m0_err}, 32'd0);
        check("rd_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        check("rd_m1_rdata", m1_rdata, 32'd0);
        check("rd_cs_idle", {30'b0, cs_dmem_n, cs_tbman_n}, 32'd3);
        next_cycle();

        // Both masters request continuously after reset: m0, m1, m0, m1
        do_reset();
        drive_m0(1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_0000, 4'h3);
        drive_m1(1'b1, 1'b0, 32'h8000_0008, 32'h5A5A_0000, 4'hC);
        read_data_tbman = 32'h7777_0008;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr%0d_m0_gnt", i), {31'b0, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_m1_gnt", i), {31'b0, m1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_addr", i), bus_addr, (i % 2 == 0) ? 32'h0000_0100 : 32'h8000_0008);
            check($sformatf("rr%0d_wdata", i), bus_wdata, (i % 2 == 0) ? 32'hA5A5_0000 : 32'h5A5A_0000);
            check($sformatf("rr%0d_be", i), {28'b0, bus_be}, (i % 2 == 0) ? 32'h3 : 32'hC);
            check($sformatf("rr%0d_we", i), {31'b0, bus_we}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_cs", i), {30'b0, cs_dmem_n, cs_tbman_n}, (i % 2 == 0) ? 32'd1 : 32'd2);
            // m1's read from the previous cycle returns while m0 is granted again.
            check($sformatf("rr%0d_m1_rv", i), {31'b0, m1_rvalid}, (i == 2) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_m0_rv", i), {31'b0, m0_rvalid}, 32'd0);
            if (i == 2) check("rr_m1_rdata", m1_rdata, 32'h7777_0008);
            next_cycle();
        end

        // m1 TBMAN read, then m0 DMEM write overlapping the return
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'hF);
        next_cycle(); // m1 returns from loop above first; grant here
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m0(1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF);
        read_data_tbman = 32'hCAFE_0001;
        read_data_dmem  = 32'h5555_5555;
        #1;
        check("b2b_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
        check("b2b_m1_rdata", m1_rdata, 32'hCAFE_0001);
        check("b2b_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("b2b_cs", {30'b0, cs_dmem_n, cs_tbman_n}, 32'd1);
        check("b2b_bus_we", {31'b0, bus_we}, 32'd1);
        check("b2b_bus_wdata", bus_wdata, 32'h0BAD_F00D);
        check("b2b_m0_rdata", m0_rdata, 32'd0);
        next_cycle();
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("wr_no_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);

        // Unmapped read by m0
        next_cycle();
        drive_m0(1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF);
        #1;
        check("um_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("um_cs", {30'b0, cs_dmem_n, cs_tbman_n}, 32'd3);
        next_cycle();
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("um_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
        check("um_m0_err", {31'b0, m0_err}, 32'd1);
        check("um_m0_rdata", m0_rdata, 32'd0);

        // Unmapped write by m1 still answers with err
        next_cycle();
        drive_m1(1'b1, 1'b1, 32'h8001_0000, 32'h1234_0000, 4'hF);
        #1;
        check("uw_cs", {30'b0, cs_dmem_n, cs_tbman_n}, 32'd3);
        next_cycle();
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("uw_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
        check("uw_m1_err", {31'b0, m1_err}, 32'd1);
        check("uw_m1_rdata", m1_rdata, 32'd0);
        check("uw_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);

        // Reset asserted while a read is in flight
        next_cycle();
        drive_m0(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'hF);
        #1;
        check("rr_m0_gnt_pre", {31'b0, m0_gnt}, 32'd1);
        next_cycle();
        n_rst = 1'b0;
        drive_m0(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'hF);
        drive_m1(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("mr%0d_rvalid", i), {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
            check($sformatf("mr%0d_gnt", i), {30'b0, m0_gnt, m1_gnt}, 32'd0);
            check($sformatf("mr%0d_cs", i), {30'b0, cs_dmem_n, cs_tbman_n}, 32'd3);
            next_cycle();
        end
        n_rst = 1'b1;
        #1;
        check("post_rst_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("post_rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        check("post_rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
        next_cycle();

        // Idle bus
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("idle%0d_cs", i), {30'b0, cs_dmem_n, cs_tbman_n}, 32'd3);
            check($sformatf("idle%0d_we", i), {31'b0, bus_we}, 32'd0);
            check($sformatf("idle%0d_rv", i), {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
            check($sformatf("idle%0d_gnt", i), {30'b0, m0_gnt, m1_gnt}, 32'd0);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
